lza_norm_unpack: RTL and testbench



---
 rtl/lza_norm_unpack.sv | 228 ++++++++++++++++++++++
 tb/tb_lza_norm_unpack.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lza_norm_unpack.sv
// lza_norm_unpack: back-end of the MAF leading-zero path.
//
// Takes the 56-bit packed adder result plus the 3-bit lane code that chose the packing.
// For each lane it counts leading zeros, left-normalizes, and returns the counts.
// The three stages are:
//   S1: register and mask the input.
//   S2: compute and register the counts.
//   S3: shift and register the outputs.
// All stages hold together while the output is stalled.
//
// Lane codes (cont):
//   000  single 56-bit lane
//   001  two 28-bit lanes, [55:28] and [27:0]
//   010  single lane with the low byte forced to zero
//   011..111  illegal: zero data, both zero flags set, err set
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      input handshake
//   in_sum[55:0]           packed adder result
//   in_cont[2:0]           lane code
//   out_valid/out_ready    output handshake
//   out_mant[55:0]         normalized mantissa(s)
//   out_lzc_h[5:0]         leading-zero count, high/only lane
//   out_lzc_l[4:0]         leading-zero count, low lane (dual mode only)
//   out_zero_h/out_zero_l  lane all-zero flags
//   out_cont[2:0]          lane code carried through
//   out_err                illegal lane code seen
//   zero_cnt[15:0]         present only with LZA_NORM_ZERO_CNT_EN defined; saturating count
//                          of zero-flagged lanes over output transfers
module lza_norm_unpack (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [55:0] in_sum,
   input  logic [2:0]  in_cont,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [55:0] out_mant,
   output logic [5:0]  out_lzc_h,
   output logic [4:0]  out_lzc_l,
   output logic        out_zero_h,
   output logic        out_zero_l,
   output logic [2:0]  out_cont,
   output logic        out_err
`ifdef LZA_NORM_ZERO_CNT_EN
   ,
   output logic [15:0] zero_cnt
`endif
);

   function automatic logic [5:0] lzc56(input logic [55:0] v);
      logic [5:0] cnt;
      logic       found;
      cnt   = 6'd0;
      found = 1'b0;
      for (int i = 55; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      cnt   = cnt + 6'd1;
         end
      end
      return cnt;
   endfunction

   function automatic logic [4:0] lzc28(input logic [27:0] v);
      logic [4:0] cnt;
      logic       found;
      cnt   = 5'd0;
      found = 1'b0;
      for (int i = 27; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      cnt   = cnt + 5'd1;
         end
      end
      return cnt;
   endfunction

   // A single global stall freezes every stage.
   logic advance;
   assign advance  = ~(out_valid & ~out_ready);
   assign in_ready = advance;

   // ---------------- S1: capture and mask ----------------
   logic        v1;
   logic [55:0] sum1;
   logic [2:0]  cont1;
   logic [55:0] sum_masked;

   always_comb begin
      sum_masked = in_sum;
      if (in_cont == 3'b010) sum_masked[7:0] = 8'h00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         sum1  <= 56'd0;
         cont1 <= 3'd0;
      end else if (advance) begin
         v1    <= in_valid;
         sum1  <= sum_masked;
         cont1 <= in_cont;
      end
   end

   // ---------------- S2: leading-zero counts ----------------
   logic        v2;
   logic [55:0] sum2;
   logic [2:0]  cont2;
   logic [5:0]  lzc_h2;
   logic [4:0]  lzc_l2;
   logic        zero_h2, zero_l2, err2;

   logic [5:0]  lzc_h_d;
   logic [4:0]  lzc_l_d;
   logic        zero_h_d, zero_l_d, err_d;

   always_comb begin
      lzc_h_d  = 6'd0;
      lzc_l_d  = 5'd0;
      zero_h_d = 1'b0;
      zero_l_d = 1'b0;
      err_d    = 1'b0;
      unique case (cont1)
         3'b000, 3'b010: begin
            lzc_h_d  = lzc56(sum1);
            zero_h_d = (sum1 == 56'd0);
         end
         3'b001: begin
            lzc_h_d  = {1'b0, lzc28(sum1[55:28])};
            lzc_l_d  = lzc28(sum1[27:0]);
            zero_h_d = (sum1[55:28] == 28'd0);
            zero_l_d = (sum1[27:0] == 28'd0);
         end
         default: begin
            zero_h_d = 1'b1;
            zero_l_d = 1'b1;
            err_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2      <= 1'b0;
         sum2    <= 56'd0;
         cont2   <= 3'd0;
         lzc_h2  <= 6'd0;
         lzc_l2  <= 5'd0;
         zero_h2 <= 1'b0;
         zero_l2 <= 1'b0;
         err2    <= 1'b0;
      end else if (advance) begin
         v2      <= v1;
         sum2    <= sum1;
         cont2   <= cont1;
         lzc_h2  <= lzc_h_d;
         lzc_l2  <= lzc_l_d;
         zero_h2 <= zero_h_d;
         zero_l2 <= zero_l_d;
         err2    <= err_d;
      end
   end

   // ---------------- S3: normalize and output ----------------
   logic [55:0] mant_d;

   always_comb begin
      mant_d = 56'd0;
      if (err2) begin
         mant_d = 56'd0;
      end else if (cont2 == 3'b001) begin
         // Lanes shift independently so no bit crosses [28].
         mant_d[55:28] = sum2[55:28] << lzc_h2;
         mant_d[27:0]  = sum2[27:0] << lzc_l2;
      end else begin
         mant_d = sum2 << lzc_h2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_mant   <= 56'd0;
         out_lzc_h  <= 6'd0;
         out_lzc_l  <= 5'd0;
         out_zero_h <= 1'b0;
         out_zero_l <= 1'b0;
         out_cont   <= 3'd0;
         out_err    <= 1'b0;
      end else if (advance) begin
         out_valid  <= v2;
         out_mant   <= mant_d;
         out_lzc_h  <= lzc_h2;
         out_lzc_l  <= lzc_l2;
         out_zero_h <= zero_h2;
         out_zero_l <= zero_l2;
         out_cont   <= cont2;
         out_err    <= err2;
      end
   end

`ifdef LZA_NORM_ZERO_CNT_EN
   logic [16:0] zero_sum;
   logic [1:0]  zero_inc;

   always_comb begin
      zero_inc = 2'd0;
      // Illegal-code beats carry both flags but are not counted.
      if (out_valid && out_ready && !out_err) begin
         zero_inc = {1'b0, out_zero_h} + {1'b0, out_zero_l};
      end
      zero_sum = {1'b0, zero_cnt} + {15'd0, zero_inc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_cnt <= 16'd0;
      end else begin
         zero_cnt <= zero_sum[16] ? 16'hFFFF : zero_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_lza_norm_unpack.sv
// Self-checking bench for lza_norm_unpack.
// Expected beats are pushed to a scoreboard queue as they are offered, and a monitor pops and
// compares them as the DUT emits. Covers reset, each lane code, a stall, and a mid-stream reset.
module tb_lza_norm_unpack;

   typedef struct packed {
      logic [55:0] mant;
      logic [5:0]  lh;
      logic [4:0]  ll;
      logic        zh;
      logic        zl;
      logic [2:0]  cont;
      logic        err;
   } exp_t;

   logic        clk, rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [55:0] in_sum, out_mant;
   logic [2:0]  in_cont, out_cont;
   logic [5:0]  out_lzc_h;
   logic [4:0]  out_lzc_l;
   logic        out_zero_h, out_zero_l, out_err;
`ifdef LZA_NORM_ZERO_CNT_EN
   logic [15:0] zero_cnt;
   int          zcnt_model = 0;
`endif

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   lza_norm_unpack dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_cont    (in_cont),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mant   (out_mant),
      .out_lzc_h  (out_lzc_h),
      .out_lzc_l  (out_lzc_l),
      .out_zero_h (out_zero_h),
      .out_zero_l (out_zero_l),
      .out_cont   (out_cont),
      .out_err    (out_err)
`ifdef LZA_NORM_ZERO_CNT_EN
      ,
      .zero_cnt   (zero_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leading zeros of the low w bits, found by locating the highest set bit from below.
   function automatic int clz(input logic [55:0] v, input int w);
      int msb = -1;
      for (int i = 0; i < w; i++) if (v[i]) msb = i;
      return w - 1 - msb;
   endfunction

   function automatic exp_t model(input logic [55:0] s, input logic [2:0] c);
      exp_t        e;
      logic [55:0] f;
      logic [27:0] hi, lo;
      int          a, b;
      e      = '0;
      e.cont = c;
      if (c > 3'd2) begin
         e.zh  = 1'b1;
         e.zl  = 1'b1;
         e.err = 1'b1;
         return e;
      end
      f = (c == 3'd2) ? {s[55:8], 8'h00} : s;
      if (c == 3'd1) begin
         hi     = f[55:28];
         lo     = f[27:0];
         a      = clz({28'h0, hi}, 28);
         b      = clz({28'h0, lo}, 28);
         e.lh   = 6'(a);
         e.ll   = 5'(b);
         e.zh   = (hi == 28'd0);
         e.zl   = (lo == 28'd0);
         e.mant = {hi << a, lo << b};
      end else begin
         a      = clz(f, 56);
         e.lh   = 6'(a);
         e.zh   = (f == 56'd0);
         e.mant = f << a;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [55:0] s, input logic [2:0] c, input exp_t e);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_sum   = s;
      in_cont  = c;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $error("FAIL accept_timeout observed=in_ready=0 expected=in_ready=1");
      end else begin
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [55:0] s, input logic [2:0] c);
      send(s, c, model(s, c));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Output monitor: compares each emitted beat against the scoreboard head.
   always @(negedge clk) begin
      exp_t obs, exp;
      #2;
      if (!rst && out_valid && out_ready) begin
         obs = '{mant: out_mant, lh: out_lzc_h, ll: out_lzc_l, zh: out_zero_h,
                 zl: out_zero_l, cont: out_cont, err: out_err};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $error("FAIL unexpected_beat observed=%0h expected=none", obs);
         end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
               failures++;
               $error("FAIL beat observed=%0h expected=%0h", obs, exp);
            end
`ifdef LZA_NORM_ZERO_CNT_EN
            if (!exp.err) zcnt_model += int'(exp.zh) + int'(exp.zl);
`endif
         end
      end
   end

   initial begin
      logic [63:0] r;
      logic [55:0] s;
      logic [2:0]  c;
      logic [55:0] snap_m;
      logic [5:0]  snap_h;
      int          nv;
      exp_t        e;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sum    = 56'd0;
      in_cont   = 3'd0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mant", 64'(out_mant), 64'd0);
      chk("rst_lzc_h", 64'(out_lzc_h), 64'd0);
      chk("rst_lzc_l", 64'(out_lzc_l), 64'd0);
      chk("rst_zero_h", 64'(out_zero_h), 64'd0);
      chk("rst_zero_l", 64'(out_zero_l), 64'd0);
      chk("rst_cont", 64'(out_cont), 64'd0);
      chk("rst_err", 64'(out_err), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed vectors with hand-derived expectations.
      e = '{mant: 56'h80_0000_0000_0000, lh: 6'd23, ll: 5'd0, zh: 1'b0, zl: 1'b0,
            cont: 3'b000, err: 1'b0};
      send(56'h00_0001_0000_0000, 3'b000, e);
      e = '{mant: {28'hC00_0000, 28'h0}, lh: 6'd26, ll: 5'd28, zh: 1'b0, zl: 1'b1,
            cont: 3'b001, err: 1'b0};
      send({28'h000_0003, 28'h0}, 3'b001, e);
      e = '{mant: 56'h0, lh: 6'd56, ll: 5'd0, zh: 1'b1, zl: 1'b0, cont: 3'b010, err: 1'b0};
      send(56'h00_0000_0000_00FF, 3'b010, e);
      e = '{mant: 56'h0, lh: 6'd0, ll: 5'd0, zh: 1'b1, zl: 1'b1, cont: 3'b101, err: 1'b1};
      send(56'h12_3456_789A_BCDE, 3'b101, e);
      e = '{mant: 56'h80_0000_0000_0000, lh: 6'd48, ll: 5'd0, zh: 1'b0, zl: 1'b0,
            cont: 3'b000, err: 1'b0};
      send(56'h00_0000_0000_0080, 3'b000, e);

      // Boundary patterns checked against the model.
      send_m(56'hFF_FFFF_FFFF_FFFF, 3'b000);
      send_m(56'h0, 3'b000);
      send_m(56'h0, 3'b001);
      send_m({28'h800_0000, 28'h000_0001}, 3'b001);
      send_m({28'h000_0001, 28'hFFF_FFFF}, 3'b001);
      send_m(56'h00_0000_0000_0100, 3'b010);
      send_m(56'h80_0000_0000_0000, 3'b010);
      send_m(56'h5, 3'b011);
      send_m(56'h5, 3'b111);

      for (int i = 0; i < 20; i++) begin
         r = {$urandom, $urandom};
         s = r[55:0] >> $urandom_range(0, 55);
         c = (i % 4 == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         send_m(s, c);
      end
      drain();

      // Stream six beats and stall the output for four cycles after the first result.
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send_m(56'h1 << (i * 9 + 1), 3'($urandom_range(0, 2)));
            end
         end
         begin
            nv = 0;
            @(negedge clk);
            while (!out_valid && nv < 50) begin
               @(negedge clk);
               nv++;
            end
            chk("stall_first_valid", 64'(out_valid), 64'd1);
            out_ready = 1'b0;
            #2;
            snap_m = out_mant;
            snap_h = out_lzc_h;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            repeat (3) begin
               @(negedge clk);
               #2;
               chk("stall_in_ready", 64'(in_ready), 64'd0);
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_mant", 64'(out_mant), 64'(snap_m));
               chk("stall_lzc_h", 64'(out_lzc_h), 64'(snap_h));
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
`ifdef LZA_NORM_ZERO_CNT_EN
      chk("zero_cnt", 64'(zero_cnt), 64'(zcnt_model));
`endif

      // Reset with three beats in flight.
      send_m(56'h1, 3'b000);
      send_m(56'h2, 3'b001);
      send_m(56'h3, 3'b010);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
`ifdef LZA_NORM_ZERO_CNT_EN
      zcnt_model = 0;
      chk("midrst_zero_cnt", 64'(zero_cnt), 64'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (out_valid) nv++;
      end
      chk("post_rst_no_output", 64'(nv), 64'd0);

      send_m(56'h00_0F00_0000_0000, 3'b000);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
